alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_decode.sv | 31 +++
 rtl/alu_issue.sv | 78 +++++++
 tb/tb_alu_issue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, latencies, opcodes and FSM states shared by issue logic and the ALU
package alu_pkg;
  localparam logic [7:0] OP_NONE = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;
  localparam logic [7:0] OP_XOR  = 8'h05;
  localparam logic [7:0] OP_AND  = 8'h06;
  localparam logic [7:0] OP_OR   = 8'h07;
  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam int LAT_ALU = 1;
  localparam int LAT_MUL = 3;
  localparam int LAT_DIV = 8;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: RV32 R/I-type instruction word to ALU op, immediate and illegal flag
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [7:0]  op,
  output logic        imm_sel,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic        illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [7:0] r_op, i_op;
  logic       unused_rs1;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign rd = instr[11:7];
  assign imm = {{20{instr[31]}}, instr[31:20]};
  assign unused_rs1 = ^instr[19:15];
  always_comb begin
    i_op = f3 == 3'd0 ? OP_ADD : f3 == 3'd4 ? OP_XOR : f3 == 3'd6 ? OP_OR : f3 == 3'd7 ? OP_AND : OP_NONE;
    r_op = f7 == 7'h00 ? i_op :
           f7 == 7'h20 ? (f3 == 3'd0 ? OP_SUB : OP_NONE) :
           f7 == 7'h01 ? (f3 == 3'd0 ? OP_MUL : f3 == 3'd4 ? OP_DIV : OP_NONE) : OP_NONE;
    op = opc == OPC_R ? r_op : opc == OPC_I ? i_op : OP_NONE;
    imm_sel = opc == OPC_I;
    illegal = op == OP_NONE;
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-issue front end holding registered operands for a multicycle ALU
module alu_issue
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = LAT_MUL,
  parameter int DIV_CYCLES = LAT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [31:0] input1,
  output logic [31:0] input2,
  output logic [7:0]  controlresult,
  input  logic [31:0] result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        wb_illegal
);
  state_t      state, state_n;
  logic [7:0]  cnt, lat, dec_op;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic        dec_imm_sel, dec_ill, accept;
  alu_decode u_dec (
    .instr(instr),
    .op(dec_op),
    .imm_sel(dec_imm_sel),
    .imm(dec_imm),
    .rd(dec_rd),
    .illegal(dec_ill)
  );
  assign in_ready = state == IDLE;
  assign wb_valid = state == DONE;
  assign accept = in_valid && in_ready;
  always_comb begin
    lat = dec_op == OP_MUL ? 8'(MUL_CYCLES - 1) : dec_op == OP_DIV ? 8'(DIV_CYCLES - 1) : 8'(LAT_ALU - 1);
    state_n = (state == IDLE && in_valid) ? EXEC :
              (state == EXEC && cnt == '0) ? DONE :
              (state == DONE && wb_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      input1 <= '0;
      input2 <= '0;
      controlresult <= OP_NONE;
      wb_data <= '0;
      wb_rd <= '0;
      wb_we <= 1'b0;
      wb_illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        input1 <= rs1_val;
        input2 <= dec_imm_sel ? dec_imm : rs2_val;
        controlresult <= dec_op;
        wb_rd <= dec_rd;
        wb_illegal <= dec_ill;
        wb_we <= dec_rd != 5'd0 && !dec_ill;
        cnt <= lat;
      end
      if (state == EXEC) begin
        if (cnt == '0)
          wb_data <= (controlresult == OP_DIV && input2 == '0) ? 32'hFFFF_FFFF : wb_illegal ? '0 : result;
        else
          cnt <= cnt - 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and random transactions against a behavioural RV32 model
module tb_alu_issue;
  localparam int MULC = 3;
  localparam int DIVC = 8;
  logic        clk = 0, rst = 0, in_valid = 0, wb_ready = 0;
  logic [31:0] instr = 0, rs1_val = 0, rs2_val = 0, result;
  logic        in_ready, wb_valid, wb_we, wb_illegal;
  logic [31:0] input1, input2, wb_data;
  logic [7:0]  controlresult;
  logic [4:0]  wb_rd;
  int vectors = 0, errs = 0;

  alu_issue #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .input1(input1), .input2(input2),
    .controlresult(controlresult), .result(result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we), .wb_illegal(wb_illegal)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; divide by zero deliberately returns junk that the unit must override.
  always_comb begin
    case (controlresult)
      8'h01: result = input1 + input2;
      8'h02: result = input1 - input2;
      8'h03: result = input1 * input2;
      8'h04: result = input2 == 0 ? 32'hDEAD_BEEF : input1 / input2;
      8'h05: result = input1 ^ input2;
      8'h06: result = input1 & input2;
      8'h07: result = input1 | input2;
      default: result = 32'h0;
    endcase
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] op2;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] imm;
    imm = {{20{ins[31]}}, ins[31:20]};
    e.rd = ins[11:7];
    e.ill = 0;
    e.op2 = b;
    e.lat = 1;
    e.op = 0;
    e.data = 0;
    if (ins[6:0] == 7'b0010011) begin
      e.op2 = imm;
      case (ins[14:12])
        3'd0: begin e.op = 8'h01; e.data = a + imm; end
        3'd4: begin e.op = 8'h05; e.data = a ^ imm; end
        3'd6: begin e.op = 8'h07; e.data = a | imm; end
        3'd7: begin e.op = 8'h06; e.data = a & imm; end
        default: e.ill = 1;
      endcase
    end else if (ins[6:0] == 7'b0110011) begin
      case ({ins[31:25], ins[14:12]})
        {7'h00, 3'd0}: begin e.op = 8'h01; e.data = a + b; end
        {7'h00, 3'd4}: begin e.op = 8'h05; e.data = a ^ b; end
        {7'h00, 3'd6}: begin e.op = 8'h07; e.data = a | b; end
        {7'h00, 3'd7}: begin e.op = 8'h06; e.data = a & b; end
        {7'h20, 3'd0}: begin e.op = 8'h02; e.data = a - b; end
        {7'h01, 3'd0}: begin e.op = 8'h03; e.data = a * b; e.lat = MULC; end
        {7'h01, 3'd4}: begin e.op = 8'h04; e.data = b == 0 ? 32'hFFFF_FFFF : a / b; e.lat = DIVC; end
        default: e.ill = 1;
      endcase
    end else e.ill = 1;
    if (e.ill) begin e.op = 0; e.data = 0; end
    e.we = e.rd != 0 && !e.ill;
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_input1", input1, 0);
    chk("rst_input2", input2, 0);
    chk("rst_ctrl", controlresult, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_ill", wb_illegal, 0);
  endtask

  task automatic chk_wb(input exp_t e);
    chk("wb_valid", wb_valid, 1);
    chk("wb_rd", wb_rd, e.rd);
    chk("wb_data", wb_data, e.data);
    chk("wb_we", wb_we, e.we);
    chk("wb_illegal", wb_illegal, e.ill);
    chk("done_in_ready", in_ready, 0);
  endtask

  task automatic run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int n;
    e = model(ins, a, b);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1; instr = ins; rs1_val = a; rs2_val = b; wb_ready = hold == 0;
    step;
    in_valid = $urandom_range(0, 1); instr = $urandom; rs1_val = $urandom; rs2_val = $urandom;
    chk("input1", input1, a);
    chk("input2", input2, e.op2);
    chk("ctrl", controlresult, e.op);
    n = 0;
    while (!wb_valid && n < 40) begin
      chk("busy_in_ready", in_ready, 0);
      chk("exec_input1", input1, a);
      chk("exec_input2", input2, e.op2);
      chk("exec_ctrl", controlresult, e.op);
      step;
      n++;
    end
    chk("latency", n, e.lat);
    chk_wb(e);
    for (int i = 0; i < hold; i++) begin
      step;
      chk_wb(e);
    end
    in_valid = 0; wb_ready = 1;
    step;
    chk("release_valid", wb_valid, 0);
    chk("release_in_ready", in_ready, 1);
    wb_ready = 0;
  endtask

  initial begin
    logic [31:0] ins, b;
    int k;
    rst = 1;
    step;
    step;
    rst = 0;
    chk_reset();
    run(rtype(7'h00, 3'd0, 5'd3), 32'd5, 32'd7, 0);
    run(rtype(7'h01, 3'd0, 5'd4), 32'h0001_0000, 32'h0001_0000, 0);
    run(rtype(7'h01, 3'd4, 5'd5), 32'd100, 32'd0, 0);
    run(rtype(7'h01, 3'd4, 5'd5), 32'd100, 32'd7, 0);
    run(itype(12'hFFF, 3'd0, 5'd0), 32'd1, 32'd9, 0);
    run(32'hFFFF_FFFF, 32'd3, 32'd4, 0);
    run(rtype(7'h20, 3'd0, 5'd9), 32'd3, 32'd10, 5);
    in_valid = 1; instr = rtype(7'h01, 3'd4, 5'd6); rs1_val = 100; rs2_val = 3; wb_ready = 1;
    step;
    in_valid = 0;
    repeat (3) step;
    rst = 1;
    step;
    rst = 0;
    chk_reset();
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_no_wb", wb_valid, 0);
      step;
    end
    wb_ready = 0;
    run(rtype(7'h00, 3'd0, 5'd3), 32'd20, 32'd22, 0);
    for (int i = 0; i < 150; i++) begin
      ins = $urandom;
      k = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: begin ins[6:0] = 7'b0110011; ins[31:25] = k == 0 ? 7'h00 : k == 1 ? 7'h20 : 7'h01; end
        1: ins[6:0] = 7'b0010011;
        2: ins[6:0] = 7'b0110011;
        default: ;
      endcase
      b = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
      run(ins, $urandom, b, $urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
